// File: rtl/ccip_tx_mux_pkg.sv
// ccip_tx_mux_pkg: CCI-P Tx types, FIFO width helper and arbiter state for the Tx round-robin mux
package ccip_tx_mux_pkg;
  localparam int CL_LEN_W = 2;
  localparam int IDX_W = 6;
  localparam logic [3:0] REQ_WRLINE_I = 4'h0;
  localparam logic [3:0] REQ_WRLINE_M = 4'h1;
  localparam logic [3:0] REQ_WRPUSH_I = 4'h2;
  typedef enum logic [1:0] {C0, C1, C2} t_tx_ch;
  typedef struct packed {
    logic [1:0]          vc_sel;
    logic [CL_LEN_W-1:0] cl_len;
    logic [3:0]          req_type;
    logic [41:0]         address;
    logic [15:0]         mdata;
  } t_ccip_c0_ReqMemHdr;
  typedef struct packed {
    logic [1:0]          vc_sel;
    logic                sop;
    logic [CL_LEN_W-1:0] cl_len;
    logic [3:0]          req_type;
    logic [41:0]         address;
    logic [15:0]         mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;
  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;
  typedef struct packed {
    logic [IDX_W-1:0]    last;
    logic                locked;
    logic [IDX_W-1:0]    lock_idx;
    logic [CL_LEN_W:0]   remaining;
  } t_arb_state;
  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction
  function automatic logic lock_start(t_if_ccip_c1_Tx t);
    return t.hdr.sop && t.hdr.cl_len != '0 &&
           (t.hdr.req_type inside {REQ_WRLINE_I, REQ_WRLINE_M, REQ_WRPUSH_I});
  endfunction
  function automatic logic [CL_LEN_W-1:0] lock_len_of(t_if_ccip_c1_Tx t);
    return t.hdr.cl_len;
  endfunction
endpackage

// File: rtl/ccip_tx_rr_arb.sv
// ccip_tx_rr_arb: work-conserving round-robin arbiter with optional multi-beat packet lock
module ccip_tx_rr_arb
  import ccip_tx_mux_pkg::*;
#(
  parameter int N = 16,
  parameter bit LOCKABLE = 1'b0
) (
  input  logic                Clk,
  input  logic                Resetb,
  input  logic [N-1:0]        req,
  input  logic                block,
  input  logic                lock_req,
  input  logic [CL_LEN_W-1:0] lock_len,
  output logic [N-1:0]        gnt,
  output logic                gnt_valid
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [CL_LEN_W:0] ONE = 1;
  t_arb_state st;
  logic [IW-1:0] rr_idx, lock_idx, idx;
  logic rr_hit, locked;
  // scan farthest-first so the nearest requester after last overwrites
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[IW'((int'(st.last) + k) % N)]) begin
        rr_idx = IW'((int'(st.last) + k) % N);
        rr_hit = 1'b1;
      end
    end
  end
  assign lock_idx = IW'(st.lock_idx);
  assign locked = LOCKABLE && st.locked;
  assign idx = locked ? lock_idx : rr_idx;
  assign gnt_valid = !block && (locked ? req[lock_idx] : rr_hit);
  assign gnt = gnt_valid ? N'(1) << idx : '0;
  always_ff @(posedge Clk)
    if (!Resetb) begin
      st <= '{last: IDX_W'(N - 1), locked: 1'b0, lock_idx: '0, remaining: '0};
    end else if (gnt_valid) begin
      st.last <= IDX_W'(idx);
      if (locked) begin
        st.remaining <= st.remaining - ONE;
        st.locked <= st.remaining != ONE;
      end else if (LOCKABLE && lock_req) begin
        st.locked <= 1'b1;
        st.lock_idx <= IDX_W'(idx);
        st.remaining <= {1'b0, lock_len};
      end
    end
endmodule

// File: rtl/ccip_tx_rr_mux.sv
// ccip_tx_rr_mux: merges N sub-AFU CCI-P Tx streams through per-channel FIFOs
// and independent round-robin arbiters into one registered host Tx port.
module ccip_tx_rr_mux
  import ccip_tx_mux_pkg::*;
#(
  parameter int N_SUBAFUS = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                 Clk,
  input  logic                 Resetb,
  input  t_if_ccip_Tx          in [N_SUBAFUS],
  input  logic                 host_c0TxAlmFull,
  input  logic                 host_c1TxAlmFull,
  output t_if_ccip_Tx          out,
  output logic [N_SUBAFUS-1:0] c0_almFull,
  output logic [N_SUBAFUS-1:0] c1_almFull,
  output logic [N_SUBAFUS-1:0] drop_err
);
  localparam int N = N_SUBAFUS;
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL_LVL = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] ALM_LVL = OW'(FIFO_DEPTH - ALMFULL_SLACK);
  t_if_ccip_Tx in_q [N];
  t_if_ccip_c0_Tx q0;
  t_if_ccip_c1_Tx q1;
  t_if_ccip_c2_Tx q2;
  logic [2:0] gv;
  logic [N-1:0] alm_n [2];
  logic [N-1:0] drop_v [3];
  logic live;
  // live lags reset release by a cycle so the first post-reset input is discarded
  always_ff @(posedge Clk)
    if (!Resetb) begin
      live <= 1'b0;
      for (int i = 0; i < N; i++) in_q[i] <= '0;
    end else begin
      live <= 1'b1;
      for (int i = 0; i < N; i++) in_q[i] <= live ? in[i] : '0;
    end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam t_tx_ch CH = t_tx_ch'(c);
    localparam int W = CH == C0 ? $bits(t_if_ccip_c0_Tx) :
                       CH == C1 ? $bits(t_if_ccip_c1_Tx) : $bits(t_if_ccip_c2_Tx);
    logic [N-1:0] wr, ne, gnt;
    logic [W-1:0] wdata [N];
    logic [W-1:0] head [N];
    logic [W-1:0] sel;
    logic lock_req;
    logic [CL_LEN_W-1:0] lock_len;
    for (genvar i = 0; i < N; i++) begin : g_f
      logic [W-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0] wp, rp;
      logic [OW-1:0] occ, occ_n;
      logic push;
      if (CH == C0) begin : g_w0
        assign wr[i] = in_q[i].c0.valid;
        assign wdata[i] = in_q[i].c0;
      end else if (CH == C1) begin : g_w1
        assign wr[i] = in_q[i].c1.valid;
        assign wdata[i] = in_q[i].c1;
      end else begin : g_w2
        assign wr[i] = in_q[i].c2.mmioRdValid;
        assign wdata[i] = in_q[i].c2;
      end
      // full is judged on pre-pop occupancy, so a write racing a pop is still dropped
      assign push = wr[i] && occ != FULL_LVL;
      assign drop_v[c][i] = wr[i] && occ == FULL_LVL;
      assign ne[i] = occ != '0;
      assign head[i] = mem[rp];
      assign occ_n = occ + OW'(push) - OW'(gnt[i]);
      if (CH != C2) begin : g_alm
        assign alm_n[c][i] = occ_n >= ALM_LVL;
      end
      always_ff @(posedge Clk)
        if (push) mem[wp] <= wdata[i];
      always_ff @(posedge Clk)
        if (!Resetb) begin
          wp <= '0;
          rp <= '0;
          occ <= '0;
        end else begin
          wp <= wp + PW'(push);
          rp <= rp + PW'(gnt[i]);
          occ <= occ_n;
        end
    end
    always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) sel = sel | (gnt[i] ? head[i] : '0);
    end
    if (CH == C1) begin : g_lock
      assign lock_req = lock_start(t_if_ccip_c1_Tx'(sel));
      assign lock_len = lock_len_of(t_if_ccip_c1_Tx'(sel));
      assign q1 = sel;
    end else begin : g_nolock
      assign lock_req = 1'b0;
      assign lock_len = '0;
      if (CH == C0) begin : g_q0
        assign q0 = sel;
      end else begin : g_q2
        assign q2 = sel;
      end
    end
    ccip_tx_rr_arb #(.N(N), .LOCKABLE(CH == C1)) u_arb (
      .Clk       (Clk),
      .Resetb    (Resetb),
      .req       (ne),
      .block     (CH == C0 ? host_c0TxAlmFull : CH == C1 ? host_c1TxAlmFull : 1'b0),
      .lock_req  (lock_req),
      .lock_len  (lock_len),
      .gnt       (gnt),
      .gnt_valid (gv[c])
    );
  end
  always_ff @(posedge Clk)
    if (!Resetb) begin
      out <= '0;
      c0_almFull <= '0;
      c1_almFull <= '0;
      drop_err <= '0;
    end else begin
      out.c0 <= gv[0] ? q0 : '0;
      out.c1 <= gv[1] ? q1 : '0;
      out.c2 <= gv[2] ? q2 : '0;
      c0_almFull <= alm_n[0];
      c1_almFull <= alm_n[1];
      drop_err <= drop_err | drop_v[0] | drop_v[1] | drop_v[2];
    end
endmodule

// File: tb/tb_ccip_tx_rr_mux.sv
// tb_ccip_tx_rr_mux: directed scenarios for the CCI-P Tx round-robin mux (N=4, depth 32, slack 8)
module tb_ccip_tx_rr_mux;
  import ccip_tx_mux_pkg::*;
  localparam int N = 4;
  logic Clk = 1'b0;
  logic Resetb = 1'b0;
  logic host_c0TxAlmFull = 1'b0;
  logic host_c1TxAlmFull = 1'b0;
  t_if_ccip_Tx in_v [N];
  t_if_ccip_Tx out;
  logic [N-1:0] c0_almFull, c1_almFull, drop_err;
  int errors = 0;
  int checks = 0;
  ccip_tx_rr_mux #(.N_SUBAFUS(N), .FIFO_DEPTH(32), .ALMFULL_SLACK(8)) dut (
    .Clk              (Clk),
    .Resetb           (Resetb),
    .in               (in_v),
    .host_c0TxAlmFull (host_c0TxAlmFull),
    .host_c1TxAlmFull (host_c1TxAlmFull),
    .out              (out),
    .c0_almFull       (c0_almFull),
    .c1_almFull       (c1_almFull),
    .drop_err         (drop_err)
  );
  always #5 Clk = ~Clk;
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic clr;
    for (int i = 0; i < N; i++) in_v[i] = '0;
  endtask
  task automatic c1_wr(input int s, input logic [15:0] md, input logic sop, input logic [1:0] len);
    in_v[s].c1.valid = 1'b1;
    in_v[s].c1.hdr.sop = sop;
    in_v[s].c1.hdr.cl_len = len;
    in_v[s].c1.hdr.req_type = REQ_WRLINE_I;
    in_v[s].c1.hdr.mdata = md;
  endtask
  task automatic test_reset;
    clr();
    Resetb = 1'b0;
    repeat (3) tick();
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out); end
    checks++;
    if ({c0_almFull, c1_almFull} !== '0) begin errors++; $display("FAIL reset_almfull: got %b expected 0", {c0_almFull, c1_almFull}); end
    checks++;
    if (drop_err !== '0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop_err); end
    Resetb = 1'b1;
    tick();
  endtask
  task automatic test_rr_c0;
    logic [16:0] exp [7];
    logic [16:0] got;
    exp = '{17'h0, 17'h0, 17'h0, 17'h10100, 17'h10102, 17'h10103, 17'h0};
    for (int k = 0; k < 6; k++) begin
      clr();
      if (k == 0) begin
        foreach (exp[i]) if (i == 0 || i == 2 || i == 3) begin
          in_v[i].c0.valid = 1'b1;
          in_v[i].c0.hdr.mdata = 16'h100 + 16'(i);
        end
      end
      tick();
      if (k + 1 >= 2) begin
        got = {out.c0.valid, out.c0.hdr.mdata};
        checks++;
        if (got !== exp[k+1]) begin errors++; $display("FAIL rr_c0 T+%0d: got %h expected %h", k + 1, got, exp[k+1]); end
      end
    end
  endtask
  task automatic test_c1_lock;
    logic [16:0] exp [15];
    logic [16:0] got;
    exp = '{17'h0, 17'h0, 17'h0, 17'h10010, 17'h10011, 17'h10012, 17'h10013, 17'h10020,
            17'h10021, 17'h10022, 17'h10023, 17'h10024, 17'h10025, 17'h0, 17'h0};
    for (int k = 0; k < 14; k++) begin
      clr();
      if (k < 4) c1_wr(1, 16'h10 + 16'(k), k == 0, 2'd3);
      if (k < 6) c1_wr(2, 16'h20 + 16'(k), 1'b1, 2'd0);
      tick();
      if (k + 1 >= 3) begin
        got = {out.c1.valid, out.c1.hdr.mdata};
        checks++;
        if (got !== exp[k+1]) begin errors++; $display("FAIL c1_lock T+%0d: got %h expected %h", k + 1, got, exp[k+1]); end
      end
    end
  endtask
  task automatic test_c1_backpressure;
    logic [16:0] exp [18];
    logic [16:0] got;
    exp = '{17'h0, 17'h0, 17'h0, 17'h10040, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0,
            17'h10041, 17'h10042, 17'h10043, 17'h10030, 17'h10031, 17'h10032, 17'h10033, 17'h0, 17'h0};
    for (int k = 0; k < 17; k++) begin
      clr();
      if (k < 4) c1_wr(1, 16'h40 + 16'(k), k == 0, 2'd3);
      if (k >= 1 && k <= 4) c1_wr(3, 16'h30 + 16'(k - 1), 1'b1, 2'd0);
      host_c1TxAlmFull = k >= 3 && k <= 7;
      tick();
      if (k + 1 >= 3) begin
        got = {out.c1.valid, out.c1.hdr.mdata};
        checks++;
        if (got !== exp[k+1]) begin errors++; $display("FAIL c1_backpressure T+%0d: got %h expected %h", k + 1, got, exp[k+1]); end
      end
    end
    host_c1TxAlmFull = 1'b0;
  endtask
  task automatic test_almfull_drop;
    int seen;
    logic [15:0] last_md;
    host_c0TxAlmFull = 1'b1;
    for (int k = 0; k < 35; k++) begin
      clr();
      if (k <= 32) begin
        in_v[0].c0.valid = 1'b1;
        in_v[0].c0.hdr.mdata = 16'(k);
      end
      tick();
      if (k + 1 == 24) begin
        checks++;
        if (c0_almFull[0] !== 1'b0) begin errors++; $display("FAIL almfull_before: got %b expected 0", c0_almFull[0]); end
      end
      if (k + 1 == 25) begin
        checks++;
        if (c0_almFull !== 4'b0001) begin errors++; $display("FAIL almfull_rise: got %b expected 0001", c0_almFull); end
      end
      if (k + 1 == 33) begin
        checks++;
        if (drop_err[0] !== 1'b0) begin errors++; $display("FAIL drop_before: got %b expected 0", drop_err[0]); end
      end
      if (k + 1 == 34) begin
        checks++;
        if (drop_err !== 4'b0001) begin errors++; $display("FAIL drop_set: got %b expected 0001", drop_err); end
        checks++;
        if (out.c0.valid !== 1'b0) begin errors++; $display("FAIL c0_blocked: got %b expected 0", out.c0.valid); end
        checks++;
        if (c1_almFull !== 4'b0000) begin errors++; $display("FAIL c1_almfull_idle: got %b expected 0000", c1_almFull); end
      end
    end
    host_c0TxAlmFull = 1'b0;
    seen = 0;
    last_md = '1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out.c0.valid === 1'b1) begin
        seen++;
        last_md = out.c0.hdr.mdata;
      end
    end
    checks++;
    if (seen != 32) begin errors++; $display("FAIL drain_count: got %0d expected 32", seen); end
    checks++;
    if (last_md !== 16'd31) begin errors++; $display("FAIL drain_last: got %h expected 001f", last_md); end
    checks++;
    if (c0_almFull[0] !== 1'b0) begin errors++; $display("FAIL almfull_fall: got %b expected 0", c0_almFull[0]); end
    checks++;
    if (drop_err[0] !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b expected 1", drop_err[0]); end
  endtask
  task automatic test_same_cycle;
    logic [2:0] v;
    for (int k = 0; k < 4; k++) begin
      clr();
      if (k == 0) begin
        in_v[3].c0.valid = 1'b1;
        in_v[3].c0.hdr.mdata = 16'h77;
        c1_wr(3, 16'h88, 1'b1, 2'd0);
        in_v[3].c1.data = 512'hABCD;
        in_v[3].c2.mmioRdValid = 1'b1;
        in_v[3].c2.hdr.tid = 9'h55;
        in_v[3].c2.data = 64'h1234;
      end
      tick();
      v = {out.c0.valid, out.c1.valid, out.c2.mmioRdValid};
      if (k + 1 == 2 || k + 1 == 4) begin
        checks++;
        if (v !== 3'b000) begin errors++; $display("FAIL same_cycle_idle T+%0d: got %b expected 000", k + 1, v); end
      end
      if (k + 1 == 3) begin
        checks++;
        if (v !== 3'b111) begin errors++; $display("FAIL same_cycle_valid: got %b expected 111", v); end
        checks++;
        if ({out.c0.hdr.mdata, out.c1.hdr.mdata, out.c1.data[15:0]} !== 48'h0077_0088_abcd) begin
          errors++; $display("FAIL same_cycle_c0c1: got %h expected 00770088abcd", {out.c0.hdr.mdata, out.c1.hdr.mdata, out.c1.data[15:0]});
        end
        checks++;
        if ({out.c2.hdr.tid, out.c2.data} !== {9'h55, 64'h1234}) begin
          errors++; $display("FAIL same_cycle_c2: got %h expected %h", {out.c2.hdr.tid, out.c2.data}, {9'h55, 64'h1234});
        end
      end
    end
  endtask
  task automatic test_reset_mid;
    int seen;
    host_c0TxAlmFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clr();
      in_v[1].c0.valid = 1'b1;
      in_v[2].c0.valid = 1'b1;
      tick();
    end
    clr();
    repeat (2) tick();
    Resetb = 1'b0;
    repeat (2) tick();
    checks++;
    if (out !== '0) begin errors++; $display("FAIL mid_reset_out: got %h expected 0", out); end
    checks++;
    if ({c0_almFull, c1_almFull, drop_err} !== '0) begin
      errors++; $display("FAIL mid_reset_flags: got %b expected 0", {c0_almFull, c1_almFull, drop_err});
    end
    Resetb = 1'b1;
    host_c0TxAlmFull = 1'b0;
    in_v[0].c0.valid = 1'b1;
    tick();
    clr();
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out.c0.valid === 1'b1 || out.c1.valid === 1'b1 || out.c2.mmioRdValid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d valid cycles expected 0", seen); end
  endtask
  initial begin
    clr();
    test_reset();
    test_rr_c0();
    test_c1_lock();
    test_c1_backpressure();
    test_almfull_drop();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ccip_tx_rr_mux.md
# ccip_tx_rr_mux

Parametrised CCI-P transmit multiplexer. It merges the `t_if_ccip_Tx` streams of `N_SUBAFUS` sub-AFUs into the single Tx port toward the host. Each sub-AFU gets its own per-channel buffering and almost-full feedback. Each channel has an independent, work-conserving round-robin arbiter that skips idle sub-AFUs, honours host almost-full, and never interleaves multi-line c1 write packets.

## Interface
- `N_SUBAFUS`, 16: number of sub-AFU ports, 2..64.
- `FIFO_DEPTH`, 32: entries per sub-AFU per channel; power of two, ≥8.
- `ALMFULL_SLACK`, 8: free entries remaining when `cX_almFull` asserts; 2..`FIFO_DEPTH`/2.
- `Clk`  in  1  sole clock.
- `Resetb`  in  1  synchronous, active-low reset.
- `in`  in  `t_if_ccip_Tx [N_SUBAFUS]`  sub-AFU Tx requests.
- `host_c0TxAlmFull`  in  1  host c0 backpressure.
- `host_c1TxAlmFull`  in  1  host c1 backpressure.
- `out`  out  `t_if_ccip_Tx`  merged Tx, registered.
- `c0_almFull`  out  `[N_SUBAFUS]`  per-sub-AFU c0 almost-full, registered.
- `c1_almFull`  out  `[N_SUBAFUS]`  per-sub-AFU c1 almost-full, registered.
- `drop_err`  out  `[N_SUBAFUS]`  sticky: a request arrived at a full FIFO.

## Operation
- Ingress: `in[i]` is registered once. A valid c0/c1 request, or an asserted c2 `mmioRdValid`, is written to that sub-AFU's channel FIFO. The FIFOs are first-word-fall-through.
- Full FIFO: the request is dropped and `drop_err[i]` is set. The bit stays set until reset.
- `cX_almFull[i]` = occupancy ≥ `FIFO_DEPTH`−`ALMFULL_SLACK`. It is registered from the post-write/post-read occupancy.
- Arbitration is independent for c0, c1 and c2. Each channel keeps a pointer `last[ch]`.
- The grant goes to the first non-empty FIFO at index `last+1`, `last+2`, … modulo `N_SUBAFUS`, wrapping at `N_SUBAFUS`−1→0. `last` updates only on a grant.
- c0: no grant while `host_c0TxAlmFull`=1.
- c1: no grant while `host_c1TxAlmFull`=1.
- c2: never blocked.
- c1 packet lock applies to a granted c1 write with `sop`=1 and `cl_len`≠0.
  - The arbiter locks to that sub-AFU for `cl_len`+1 beats in total; beat count uses `cl_len` width + 1 bit.
  - While locked, other sub-AFUs are not granted c1.
  - Host almFull or an empty locked FIFO stalls the packet; the lock is kept.
  - The lock releases after the final beat is granted.
- Egress: each granted head is popped and registered into `out.cX`. A non-granted channel drives all zeros that cycle, including valid.
- At most one request per channel per cycle. c0, c1 and c2 may all be valid in the same cycle, from different or the same sub-AFUs.

## Timing
- Reset (`Resetb`=0, sampled at `Clk`):
  - `out` = 0.
  - `c0_almFull`/`c1_almFull` = 0.
  - `drop_err` = 0.
  - FIFOs empty; `last[ch]` = `N_SUBAFUS`−1, so index 0 wins first.
  - Lock cleared.
- Reset mid-packet discards all buffered requests and the lock.
- Inputs are ignored during reset and in the first cycle after reset release.
- Latency with FIFO empty and channel unblocked: request at `in` in cycle T → `out` valid in cycle T+3. That is ingress register (T+1), FIFO head visible and granted (T+2), output register (T+3).
- Host almFull sampled 1 in cycle T → no grant for that channel in T, so no new valid on `out` at T+1.
- Simultaneous write and pop on the same FIFO leaves occupancy unchanged. A write to a full FIFO in the same cycle as a pop is still dropped; full is evaluated pre-pop.
- Throughput: 1 request per channel per cycle sustained.

## Structure
- Shared package `ccip_tx_mux_pkg`: FIFO pointer/occupancy widths derived from `FIFO_DEPTH`, `t_tx_ch` enum (C0, C1, C2), and a `t_arb_state` struct (last pointer, locked flag, locked index, remaining beats).
- Sub-module `ccip_tx_rr_arb` (parameters `N`, `LOCKABLE`): inputs are the non-empty vector, block and lock request; outputs are a one-hot grant and a grant-valid. It is instantiated three times, with `LOCKABLE`=1 only for c1.
- FIFO storage is inline in the top.

## Test plan
- With N=4: sub-AFUs 0,2,3 each issue one c0 read at T → `out.c0` valid at T+3, T+4, T+5 carrying sources 0, 2, 3. Sub-AFU 1 is skipped with no idle slot.
- Sub-AFU 1 sends a 4-line c1 write (`cl_len`=3) while sub-AFU 2 streams single writes → `out.c1` shows four consecutive beats from 1, then sub-AFU 2 resumes. No interleave occurs.
- `host_c1TxAlmFull`=1 for 5 cycles mid-packet → no c1 valid for those 5 cycles. The remaining beats then continue from the same sub-AFU.
- With DEPTH=32, SLACK=8 and host c0 blocked: sub-AFU 0 pushes 24 reads → `c0_almFull[0]` rises after the 24th write. The 33rd push sets `drop_err[0]`.
- c0, c1 and an MMIO response from sub-AFU 3 arrive in the same cycle → all three appear on `out` in one cycle, 3 cycles later.
- Assert reset with 10 requests buffered → all outputs are 0. After release, nothing is emitted until new input arrives.
